// File: rtl/wb_checker_pkg.sv
// Shared types for the writeback checker: FSM state encoding and verdict reason codes.
package wb_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  localparam logic [2:0] RSN_NONE     = 3'd0;
  localparam logic [2:0] RSN_MISMATCH = 3'd1;
  localparam logic [2:0] RSN_MISSING  = 3'd2;
  localparam logic [2:0] RSN_EXTRA    = 3'd3;
  localparam logic [2:0] RSN_TIMEOUT  = 3'd4;

endpackage

// File: rtl/wb_checker_if.sv
// Observed CPU retire bus: register-file write port plus current PC.
interface wb_checker_if #(
    parameter int REG_BITS = 5,
    parameter int WIDTH    = 32,
    parameter int PC_W     = 32
) ();
    logic                wb_valid;
    logic [REG_BITS-1:0] wb_reg;
    logic [WIDTH-1:0]    wb_data;
    logic [PC_W-1:0]     pc;

    modport master (output wb_valid, wb_reg, wb_data, pc);
    modport slave  (input  wb_valid, wb_reg, wb_data, pc);
endinterface

// File: rtl/wb_exp_table.sv
// Expected (register, value) table: synchronous write, combinational read, no reset.
module wb_exp_table #(
    parameter int REG_BITS = 5,
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int AW       = 4
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [REG_BITS-1:0] wreg,
    input  logic [WIDTH-1:0]    wdata,
    input  logic [AW-1:0]       raddr,
    output logic [REG_BITS-1:0] rreg,
    output logic [WIDTH-1:0]    rdata
);
    logic [REG_BITS+WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= {wreg, wdata};
    end

    assign {rreg, rdata} = mem[raddr];
endmodule

// File: rtl/wb_checker.sv
// Writeback checker: compares retired register writes against an ordered table, latches a verdict.
// Optional WB_CHECKER_HIST_EN keeps the last four non-r0 writebacks for post-mortem reads.
module wb_checker
    import wb_checker_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int REG_BITS = 5,
    parameter  int PC_W     = 32,
    parameter  int DEPTH    = 16,
    parameter  int TIMEOUT  = 1024,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                exp_we,
    input  logic [AW-1:0]       exp_addr,
    input  logic [REG_BITS-1:0] exp_reg,
    input  logic [WIDTH-1:0]    exp_data,
    input  logic [AW:0]         exp_count,
    input  logic [PC_W-1:0]     halt_pc,
    input  logic                start,
    wb_checker_if.slave         wb,
    output logic                done,
    output logic                pass,
    output logic [2:0]          reason,
    output logic [AW:0]         fail_idx,
    output logic [REG_BITS-1:0] fail_reg,
    output logic [WIDTH-1:0]    fail_data,
    output logic [15:0]         cycles,
    input  logic [1:0]          hist_sel,
    output logic [REG_BITS-1:0] hist_reg,
    output logic [WIDTH-1:0]    hist_data
);
    state_e              state_q, state_d;
    logic [AW:0]         ptr_q, ptr_d, cnt_q, cnt_d, ptr_a;
    logic [PC_W-1:0]     halt_q, halt_d;
    logic [15:0]         cyc_q, cyc_d;
    logic [2:0]          rsn_q, rsn_d;
    logic [AW:0]         fidx_q, fidx_d;
    logic [REG_BITS-1:0] freg_q, freg_d, tbl_reg;
    logic [WIDTH-1:0]    fdata_q, fdata_d, tbl_data;
    logic                arm, wb_live, verdict;

    wb_exp_table #(.REG_BITS(REG_BITS), .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_tbl (
        .clk   (clk),
        .we    (exp_we && state_q == ST_IDLE),
        .waddr (exp_addr),
        .wreg  (exp_reg),
        .wdata (exp_data),
        .raddr (ptr_q[AW-1:0]),
        .rreg  (tbl_reg),
        .rdata (tbl_data)
    );

    assign arm     = start && state_q != ST_RUN;
    assign wb_live = state_q == ST_RUN && wb.wb_valid && wb.wb_reg != '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        halt_d  = halt_q;
        cyc_d   = cyc_q;
        rsn_d   = rsn_q;
        fidx_d  = fidx_q;
        freg_d  = freg_q;
        fdata_d = fdata_q;
        ptr_a   = ptr_q;
        verdict = 1'b0;
        if (arm) begin
            state_d = ST_RUN;
            cnt_d   = (exp_count > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : exp_count;
            halt_d  = halt_pc;
            ptr_d   = '0;
            cyc_d   = '0;
            rsn_d   = RSN_NONE;
            fidx_d  = '0;
            freg_d  = '0;
            fdata_d = '0;
        end else if (state_q == ST_RUN) begin
            cyc_d = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
            // Writeback is judged before halt so a final write in the halt cycle still counts.
            if (wb_live) begin
                if (ptr_q == cnt_q || {tbl_reg, tbl_data} != {wb.wb_reg, wb.wb_data}) begin
                    verdict = 1'b1;
                    state_d = ST_FAIL;
                    rsn_d   = (ptr_q == cnt_q) ? RSN_EXTRA : RSN_MISMATCH;
                    fidx_d  = ptr_q;
                    freg_d  = wb.wb_reg;
                    fdata_d = wb.wb_data;
                end else begin
                    ptr_a = ptr_q + (AW+1)'(1);
                end
            end
            if (!verdict && wb.pc == halt_q) begin
                verdict = 1'b1;
                state_d = (ptr_a == cnt_q) ? ST_PASS : ST_FAIL;
                rsn_d   = (ptr_a == cnt_q) ? RSN_NONE : RSN_MISSING;
                fidx_d  = (ptr_a == cnt_q) ? '0 : ptr_a;
            end
            if (!verdict && cyc_q == 16'(TIMEOUT - 1)) begin
                state_d = ST_FAIL;
                rsn_d   = RSN_TIMEOUT;
                fidx_d  = ptr_a;
            end
            ptr_d = ptr_a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            halt_q  <= '0;
            cyc_q   <= '0;
            rsn_q   <= RSN_NONE;
            fidx_q  <= '0;
            freg_q  <= '0;
            fdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            halt_q  <= halt_d;
            cyc_q   <= cyc_d;
            rsn_q   <= rsn_d;
            fidx_q  <= fidx_d;
            freg_q  <= freg_d;
            fdata_q <= fdata_d;
        end
    end

    assign done      = state_q == ST_PASS || state_q == ST_FAIL;
    assign pass      = state_q == ST_PASS;
    assign reason    = rsn_q;
    assign fail_idx  = fidx_q;
    assign fail_reg  = freg_q;
    assign fail_data = fdata_q;
    assign cycles    = cyc_q;

`ifdef WB_CHECKER_HIST_EN
    logic [3:0][REG_BITS-1:0] hreg_q;
    logic [3:0][WIDTH-1:0]    hdata_q;

    always_ff @(posedge clk) begin
        if (reset || arm) begin
            hreg_q  <= '0;
            hdata_q <= '0;
        end else if (wb_live) begin
            hreg_q  <= {hreg_q[2:0], wb.wb_reg};
            hdata_q <= {hdata_q[2:0], wb.wb_data};
        end
    end

    assign hist_reg  = hreg_q[hist_sel];
    assign hist_data = hdata_q[hist_sel];
`else
    logic unused_hist_sel;
    assign unused_hist_sel = ^hist_sel;
    assign hist_reg  = '0;
    assign hist_data = '0;
`endif
endmodule
